heading_tracker: RTL and testbench
==================================

HEADING_TRACKER -- requirements
Module: heading_tracker

Interface
REQ-001 SHALL have parameter MAX_STEP, default 6, the maximum heading change in degrees per frame step.
REQ-002 SHALL have parameter DEADBAND, default 2, the largest absolute angular error in degrees that produces no step.
REQ-003 SHALL have port clk_in  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_in  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port angle_in  input  32 (signed)  target angle in degrees; legal range 0..359.
REQ-006 SHALL have port angle_valid_in  input  1  angle_in is valid this cycle.
REQ-007 SHALL have port angle_ready_out  output  1  block can accept a target angle this cycle.
REQ-008 SHALL have port frame_tick_in  input  1  single-cycle frame strobe that permits one step.
REQ-009 SHALL have port heading_out  output  9 (unsigned)  displayed heading in degrees, 0..359.
REQ-010 SHALL have port sector_out  output  4  sprite sector index, 0..15.
REQ-011 SHALL have port heading_valid_out  output  1  one-cycle pulse when heading_out and sector_out update.
REQ-012 SHALL have port moving_out  output  1  high while the angular error exceeds DEADBAND.
REQ-013 SHALL have port range_err_out  output  1  one-cycle pulse when an out-of-range angle is rejected.

Function
REQ-014 SHALL implement the states IDLE, DIFF, WAIT_TICK and STEP.
REQ-015 SHALL drive angle_ready_out = (state is IDLE or WAIT_TICK) and not rst_in.
REQ-016 SHALL define a transfer as angle_valid_in and angle_ready_out both high at a rising edge.
REQ-017 SHALL, on a transfer with 0 <= angle_in <= 359, load the target register from angle_in[8:0] and go to DIFF.
REQ-018 SHALL, on a transfer with angle_in < 0 or angle_in > 359, leave the target unchanged, pulse range_err_out on the next cycle, and remain in the current state.
REQ-019 SHALL, in DIFF, compute d = target - heading (signed, at least 10 bits), then wrap it: if d > 180 then d -= 360; if d <= -180 then d += 360; result range is -179..180.
REQ-020 SHALL, in DIFF, register moving_out = (|d| > DEADBAND) and go to WAIT_TICK; DIFF lasts exactly one cycle.
REQ-021 SHALL, in WAIT_TICK, go to STEP when frame_tick_in or tick_pending is high; a valid-range transfer in the same cycle has priority and goes to DIFF, keeping tick_pending set.
REQ-022 SHALL set tick_pending when frame_tick_in is high in IDLE, DIFF or STEP, and clear it on entry to STEP unless frame_tick_in is high in that STEP cycle.
REQ-023 SHALL, in STEP, apply step = 0 if |d| <= DEADBAND, otherwise sign(d) * min(|d|, MAX_STEP).
REQ-024 SHALL wrap the STEP result: a sum >= 360 has 360 subtracted; a sum < 0 has 360 added.
REQ-025 SHALL, in STEP, update heading_out and sector_out on the exit edge and pulse heading_valid_out for exactly that one following cycle, including when step = 0.
REQ-026 SHALL, after STEP, go to DIFF if the new error exceeds DEADBAND, otherwise to IDLE with moving_out cleared.
REQ-027 SHALL compute sector_out = ((2*heading + 22) / 45) mod 16 using integer division, registered together with heading_out.
REQ-028 SHALL give a latency of: transfer at edge N -> DIFF at N -> WAIT_TICK at N+1; tick seen at edge M -> heading_out valid after edge M+1.

Reset
REQ-029 SHALL, while rst_in is high and independent of clk_in, force state IDLE, heading 0, target 0, sector_out 0, tick_pending 0, moving_out 0, heading_valid_out 0, range_err_out 0 and angle_ready_out 0.
REQ-030 SHALL, on reset assertion mid-operation, abort any pending step with no heading_valid_out pulse, and resume in IDLE on the first edge after deassertion.

Verification
REQ-031 SHALL cover reset: assert rst_in mid-WAIT_TICK -> heading_out 0, sector_out 0 and all strobes 0 immediately; after release, angle_ready_out is 1.
REQ-032 SHALL cover convergence: from heading 0, accept 30 and apply 5 ticks -> heading_out goes 6, 12, 18, 24, 30 with 5 heading_valid_out pulses and moving_out 0 after the last pulse.
REQ-033 SHALL cover wrap-around: from heading 0, accept 350 and apply 2 ticks -> heading_out 354 then 350, sector_out 0 then 0; a 3rd tick leaves 350.
REQ-034 SHALL cover the tie and the deadband: from heading 0, target 180 plus a tick -> heading_out 6; from heading 30, target 32 plus a tick -> heading_out 30 with moving_out 0.
REQ-035 SHALL cover range errors: angle_in = -5, then 360 -> two range_err_out pulses, target and heading unchanged, no state change.
REQ-036 SHALL cover the pending tick: a tick during DIFF followed by no further ticks -> exactly one step taken on reaching WAIT_TICK.

Source files
------------

// File: rtl/heading_tracker.sv
// heading_tracker: steps a displayed heading toward a target angle, at most MAX_STEP degrees per frame tick
module heading_tracker #(
  parameter int MAX_STEP = 6,
  parameter int DEADBAND = 2
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic signed [31:0] angle_in,
  input  logic               angle_valid_in,
  output logic               angle_ready_out,
  input  logic               frame_tick_in,
  output logic [8:0]         heading_out,
  output logic [3:0]         sector_out,
  output logic               heading_valid_out,
  output logic               moving_out,
  output logic               range_err_out
);
  typedef enum logic [1:0] {IDLE, DIFF, WAIT_TICK, STEP} state_t;
  localparam logic signed [9:0] DB = 10'(DEADBAND);
  localparam logic signed [9:0] MS = 10'(MAX_STEP);
  state_t state, state_nx;
  logic [8:0] target, heading_nx;
  logic signed [9:0] err, d_now, new_err, err_abs, step_mag, step, sum;
  logic tick_pending, load, bad, in_range;
  // Shortest signed path from h to t, in -179..180
  function automatic logic signed [9:0] wrap_diff(input logic [8:0] t, input logic [8:0] h);
    logic signed [9:0] d;
    d = $signed({1'b0, t}) - $signed({1'b0, h});
    return d > 10'sd180 ? d - 10'sd360 : d <= -10'sd180 ? d + 10'sd360 : d;
  endfunction
  function automatic logic signed [9:0] abs10(input logic signed [9:0] v);
    return v < 0 ? -v : v;
  endfunction
  function automatic logic [3:0] sector_of(input logic [8:0] h);
    logic [10:0] s;
    s = {1'b0, h, 1'b0} + 11'd22;
    return 4'(s / 11'd45);
  endfunction
  assign angle_ready_out = (state == IDLE || state == WAIT_TICK) && !rst_in;
  assign in_range = angle_in >= 32'sd0 && angle_in <= 32'sd359;
  assign load = angle_valid_in && angle_ready_out && in_range;
  assign bad = angle_valid_in && angle_ready_out && !in_range;
  always_comb begin
    d_now = wrap_diff(target, heading_out);
    err_abs = abs10(err);
    step_mag = err_abs <= DB ? 10'sd0 : err_abs > MS ? MS : err_abs;
    step = err < 0 ? -step_mag : step_mag;
    sum = $signed({1'b0, heading_out}) + step;
    heading_nx = sum >= 10'sd360 ? 9'(sum - 10'sd360) : sum < 0 ? 9'(sum + 10'sd360) : sum[8:0];
    new_err = wrap_diff(target, heading_nx);
    state_nx = state;
    unique case (state)
      IDLE:      state_nx = load ? DIFF : IDLE;
      DIFF:      state_nx = WAIT_TICK;
      WAIT_TICK: state_nx = load ? DIFF : bad ? WAIT_TICK : (frame_tick_in || tick_pending) ? STEP : WAIT_TICK;
      STEP:      state_nx = abs10(new_err) > DB ? DIFF : IDLE;
      default:   state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= IDLE;
      target <= '0;
      heading_out <= '0;
      sector_out <= '0;
      err <= '0;
      tick_pending <= 1'b0;
      moving_out <= 1'b0;
      heading_valid_out <= 1'b0;
      range_err_out <= 1'b0;
    end else begin
      state <= state_nx;
      tick_pending <= state_nx == STEP ? 1'b0 : tick_pending | frame_tick_in;
      range_err_out <= bad;
      heading_valid_out <= state == STEP;
      if (load) target <= angle_in[8:0];
      if (state == DIFF) begin
        err <= d_now;
        moving_out <= abs10(d_now) > DB;
      end
      if (state == STEP) begin
        heading_out <= heading_nx;
        sector_out <= sector_of(heading_nx);
        if (abs10(new_err) <= DB) moving_out <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_heading_tracker.sv
// tb_heading_tracker: directed scenario tasks for heading_tracker with hand-computed expectations
module tb_heading_tracker;
  logic clk = 0, rst = 1;
  logic signed [31:0] angle = 0;
  logic angle_valid = 0, frame_tick = 0;
  logic ready, hv, moving, rerr;
  logic [8:0] heading;
  logic [3:0] sector;
  int tests = 0, fails = 0, hv_count = 0, rerr_count = 0;

  heading_tracker dut (
    .clk_in(clk), .rst_in(rst), .angle_in(angle), .angle_valid_in(angle_valid),
    .angle_ready_out(ready), .frame_tick_in(frame_tick), .heading_out(heading),
    .sector_out(sector), .heading_valid_out(hv), .moving_out(moving), .range_err_out(rerr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (hv) hv_count <= hv_count + 1;
    if (rerr) rerr_count <= rerr_count + 1;
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1; angle_valid = 0; frame_tick = 0;
    cyc(2);
    rst = 0;
    cyc(1);
  endtask

  task automatic send(input int a);
    angle = a; angle_valid = 1;
    cyc(1);
    angle_valid = 0;
  endtask

  task automatic step_tick(output logic [8:0] h, output logic [3:0] s, output bit ok);
    int n = 0;
    while (!ready && n < 20) begin cyc(1); n++; end
    frame_tick = 1;
    cyc(1);
    frame_tick = 0;
    n = 0;
    while (!hv && n < 20) begin cyc(1); n++; end
    ok = hv; h = heading; s = sector;
  endtask

  task automatic test_reset();
    logic [8:0] h; logic [3:0] s; bit ok;
    do_reset();
    tests++; if (heading !== 9'd0 || sector !== 4'd0) begin fails++; $display("FAIL reset_state heading=%0d sector=%0d want 0 0", heading, sector); end
    tests++; if (ready !== 1'b1 || hv !== 1'b0 || moving !== 1'b0 || rerr !== 1'b0) begin fails++; $display("FAIL reset_flags ready=%b hv=%b moving=%b rerr=%b want 1 0 0 0", ready, hv, moving, rerr); end
    send(100);
    step_tick(h, s, ok);
    cyc(2);
    tests++; if (heading !== 9'd6 || ready !== 1'b1 || moving !== 1'b1) begin fails++; $display("FAIL reset_pre heading=%0d ready=%b moving=%b want 6 1 1", heading, ready, moving); end
    h = 9'(hv_count);
    rst = 1;
    #2;
    tests++; if (heading !== 9'd0 || sector !== 4'd0 || hv !== 1'b0 || moving !== 1'b0 || rerr !== 1'b0 || ready !== 1'b0) begin fails++; $display("FAIL reset_async heading=%0d sector=%0d hv=%b moving=%b rerr=%b ready=%b want all 0", heading, sector, hv, moving, rerr, ready); end
    frame_tick = 1;
    cyc(2);
    frame_tick = 0;
    rst = 0;
    cyc(3);
    tests++; if (ready !== 1'b1 || heading !== 9'd0 || hv_count !== int'(h)) begin fails++; $display("FAIL reset_release ready=%b heading=%0d pulses=%0d want 1 0 %0d", ready, heading, hv_count, h); end
  endtask

  task automatic test_convergence();
    logic [8:0] h; logic [3:0] s; bit ok; int c0;
    do_reset();
    c0 = hv_count;
    send(30);
    for (int i = 1; i <= 5; i++) begin
      step_tick(h, s, ok);
      tests++; if (ok !== 1'b1 || h !== 9'(6 * i)) begin fails++; $display("FAIL conv_step%0d heading=%0d valid=%b want %0d 1", i, h, ok, 6 * i); end
    end
    tests++; if (moving !== 1'b0 || s !== 4'd1) begin fails++; $display("FAIL conv_final moving=%b sector=%0d want 0 1", moving, s); end
    cyc(3);
    tests++; if (hv_count - c0 !== 5) begin fails++; $display("FAIL conv_pulses got=%0d want 5", hv_count - c0); end
  endtask

  task automatic test_wrap();
    logic [8:0] h; logic [3:0] s; bit ok; int c0;
    do_reset();
    send(350);
    step_tick(h, s, ok);
    tests++; if (ok !== 1'b1 || h !== 9'd354 || s !== 4'd0) begin fails++; $display("FAIL wrap_1 heading=%0d sector=%0d want 354 0", h, s); end
    step_tick(h, s, ok);
    tests++; if (ok !== 1'b1 || h !== 9'd350 || s !== 4'd0 || moving !== 1'b0) begin fails++; $display("FAIL wrap_2 heading=%0d sector=%0d moving=%b want 350 0 0", h, s, moving); end
    cyc(1);
    c0 = hv_count;
    frame_tick = 1;
    cyc(1);
    frame_tick = 0;
    cyc(5);
    tests++; if (heading !== 9'd350 || hv_count !== c0) begin fails++; $display("FAIL wrap_3 heading=%0d pulses=%0d want 350 0", heading, hv_count - c0); end
  endtask

  task automatic test_tie_deadband();
    logic [8:0] h; logic [3:0] s; bit ok;
    do_reset();
    send(180);
    step_tick(h, s, ok);
    tests++; if (ok !== 1'b1 || h !== 9'd6) begin fails++; $display("FAIL tie heading=%0d want 6", h); end
    do_reset();
    send(30);
    repeat (5) step_tick(h, s, ok);
    send(32);
    cyc(1);
    tests++; if (moving !== 1'b0) begin fails++; $display("FAIL deadband_moving moving=%b want 0", moving); end
    step_tick(h, s, ok);
    tests++; if (ok !== 1'b1 || h !== 9'd30 || moving !== 1'b0) begin fails++; $display("FAIL deadband heading=%0d valid=%b moving=%b want 30 1 0", h, ok, moving); end
  endtask

  task automatic test_range();
    logic [8:0] h; logic [3:0] s; bit ok; int r0;
    do_reset();
    send(30);
    step_tick(h, s, ok);
    cyc(2);
    r0 = rerr_count;
    send(-5);
    tests++; if (rerr !== 1'b1 || ready !== 1'b1) begin fails++; $display("FAIL range_neg rerr=%b ready=%b want 1 1", rerr, ready); end
    send(360);
    tests++; if (rerr !== 1'b1 || ready !== 1'b1 || heading !== 9'd6) begin fails++; $display("FAIL range_big rerr=%b ready=%b heading=%0d want 1 1 6", rerr, ready, heading); end
    cyc(1);
    tests++; if (rerr !== 1'b0 || rerr_count - r0 !== 2) begin fails++; $display("FAIL range_pulses rerr=%b count=%0d want 0 2", rerr, rerr_count - r0); end
    repeat (4) step_tick(h, s, ok);
    tests++; if (h !== 9'd30 || moving !== 1'b0) begin fails++; $display("FAIL range_target heading=%0d moving=%b want 30 0", h, moving); end
  endtask

  task automatic test_pending();
    int c0;
    do_reset();
    c0 = hv_count;
    send(30);
    frame_tick = 1;
    cyc(1);
    frame_tick = 0;
    cyc(2);
    tests++; if (hv !== 1'b1 || heading !== 9'd6) begin fails++; $display("FAIL pending_step hv=%b heading=%0d want 1 6", hv, heading); end
    cyc(10);
    tests++; if (hv_count - c0 !== 1 || heading !== 9'd6 || moving !== 1'b1) begin fails++; $display("FAIL pending_once pulses=%0d heading=%0d moving=%b want 1 6 1", hv_count - c0, heading, moving); end
  endtask

  initial begin
    test_reset();
    test_convergence();
    test_wrap();
    test_tie_deadband();
    test_range();
    test_pending();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
